// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
// State encoding and default operand width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full adder cell.
// It is time-shared by the serial adder sequencer.
module serial_adder_ctrl_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell, LSB first, one bit per clock.
// Handshake is start/ready in, done pulse out; the result stays registered.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_opa;
    logic [WIDTH-1:0] r_opb;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;
    logic             w_fa_sum;
    logic             w_fa_cout;
    logic             w_last;

    serial_adder_ctrl_fa u_fa (
        .i_a    (r_opa[0]),
        .i_b    (r_opb[0]),
        .i_cin  (r_carry),
        .o_sum  (w_fa_sum),
        .o_cout (w_fa_cout)
    );

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_carry <= w_fa_cout;
                    r_acc   <= {w_fa_sum, r_acc[WIDTH-1:1]};
                    r_cnt   <= r_cnt + CW'(1);
                    // Publish only the complete word, never a partial sum
                    if (w_last) begin
                        r_sum  <= {w_fa_sum, r_acc[WIDTH-1:1]};
                        r_cout <= w_fa_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign sum   = r_sum;
    assign cout  = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=2).
// Expected results come from plain integer addition a+b+cin.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       ready;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       s2_start;
    logic [1:0] s2_a;
    logic [1:0] s2_b;
    logic       s2_cin;
    logic       s2_ready;
    logic       s2_done;
    logic [1:0] s2_sum;
    logic       s2_cout;

    int n_chk  = 0;
    int n_fail = 0;

    logic [8:0] last_res;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s2_start),
        .a     (s2_a),
        .b     (s2_b),
        .cin   (s2_cin),
        .ready (s2_ready),
        .done  (s2_done),
        .sum   (s2_sum),
        .cout  (s2_cout)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [8:0] ref8(input logic [7:0] x,
                                        input logic [7:0] y,
                                        input logic c);
        return 9'({1'b0, x}) + 9'({1'b0, y}) + 9'(c);
    endfunction

    function automatic logic [2:0] ref2(input logic [1:0] x,
                                        input logic [1:0] y,
                                        input logic c);
        return 3'({1'b0, x}) + 3'({1'b0, y}) + 3'(c);
    endfunction

    // mode 0: quiet, 1: random input noise, 2: re-request 11+22 while busy
    task automatic run_op(input logic [7:0] x, input logic [7:0] y,
                          input logic c, input int mode);
        int n;
        bit seen;
        logic [8:0] e;
        e = ref8(x, y, c);
        check("pre_ready", ready, 1);
        start = 1'b1;
        a = x;
        b = y;
        cin = c;
        tick();
        start = 1'b0;
        check("busy_after_accept", ready, 0);
        check("no_done_at_accept", done, 0);
        n = 0;
        seen = 0;
        while (!seen && n < 24) begin
            if (mode == 1) begin
                start = 1'($urandom);
                a = 8'($urandom);
                b = 8'($urandom);
                cin = 1'($urandom);
            end else if (mode == 2) begin
                start = 1'b1;
                a = 8'h11;
                b = 8'h22;
                cin = 1'b0;
            end
            tick();
            n++;
            if (done) seen = 1;
            else check("held_result", {cout, sum}, last_res);
        end
        check("done_seen", seen, 1);
        check("latency", n, 8);
        check("sum", sum, e[7:0]);
        check("cout", cout, e[8]);
        last_res = e;
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        tick();
        check("done_one_cycle", done, 0);
        check("ready_back", ready, 1);
        check("result_hold", {cout, sum}, e);
    endtask

    initial begin
        logic [8:0] q8[$];
        logic [2:0] q2[$];
        logic [8:0] e;
        logic [2:0] e2;
        int cyc;
        int last_done;
        int ndone;
        int k;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
        s2_start = 1'b0;
        s2_a = '0;
        s2_b = '0;
        s2_cin = 1'b0;
        last_res = '0;

        repeat (3) tick();
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ready2", s2_ready, 1);
        check("rst_sum2", {s2_cout, s2_sum}, 0);
        rst_n = 1'b1;
        tick();
        check("idle_after_release", ready, 1);

        run_op(8'hFF, 8'h01, 1'b0, 0);
        run_op(8'h5A, 8'h3C, 1'b1, 1);
        run_op(8'h80, 8'h80, 1'b1, 2);
        check("no_extra_accept", ready, 1);
        run_op(8'hFF, 8'hFF, 1'b1, 0);
        run_op(8'h00, 8'h00, 1'b0, 0);

        // abort in the middle of an operation
        start = 1'b1;
        a = 8'hC3;
        b = 8'h7E;
        cin = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        check("busy_before_abort", ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_cout", cout, 0);
        tick();
        check("abort_no_done", done, 0);
        rst_n = 1'b1;
        tick();
        last_res = '0;
        run_op(8'hC3, 8'h7E, 1'b1, 0);

        for (int i = 0; i < 20; i++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom),
                   int'($urandom_range(0, 1)));
        end

        // back-to-back stream, start held high
        cyc = 0;
        last_done = -1;
        ndone = 0;
        start = 1'b1;
        while (ndone < 300 && cyc < 6000) begin
            a = 8'($urandom);
            b = 8'($urandom);
            cin = 1'($urandom);
            if (ready) q8.push_back(ref8(a, b, cin));
            tick();
            cyc++;
            if (done) begin
                if (q8.size() == 0) begin
                    check("stream_underflow", 1, 0);
                end else begin
                    e = q8.pop_front();
                    check("stream_sum", sum, e[7:0]);
                    check("stream_cout", cout, e[8]);
                end
                if (last_done >= 0) check("stream_period", cyc - last_done, 10);
                last_done = cyc;
                ndone++;
            end
        end
        check("stream_count", ndone, 300);
        start = 1'b0;
        repeat (12) tick();
        check("stream_idle", ready, 1);

        // WIDTH=2 exhaustive, start held high
        cyc = 0;
        last_done = -1;
        ndone = 0;
        k = 0;
        s2_start = 1'b1;
        while (ndone < 32 && cyc < 400) begin
            if (s2_ready && k < 32) begin
                s2_a = 2'(k);
                s2_b = 2'(k >> 2);
                s2_cin = 1'(k >> 4);
                q2.push_back(ref2(s2_a, s2_b, s2_cin));
                k++;
                if (k == 32) begin
                    tick();
                    cyc++;
                    s2_start = 1'b0;
                    if (s2_done) check("w2_early_done", 1, 0);
                    continue;
                end
            end else begin
                s2_a = 2'($urandom);
                s2_b = 2'($urandom);
                s2_cin = 1'($urandom);
            end
            tick();
            cyc++;
            if (s2_done) begin
                if (q2.size() == 0) begin
                    check("w2_underflow", 1, 0);
                end else begin
                    e2 = q2.pop_front();
                    check("w2_result", {s2_cout, s2_sum}, e2);
                end
                if (last_done >= 0) check("w2_period", cyc - last_done, 4);
                last_done = cyc;
                ndone++;
            end
        end
        check("w2_count", ndone, 32);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
